// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, register index width
// and the load-use hazard compare.
package pipeline_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic {
        S_RUN     = 1'b0,
        S_MD_WAIT = 1'b1
    } hcu_state_e;

    // A load into r0 never produces a value, so it can never force a stall.
    function automatic logic load_use_hazard(
        input logic             ex_mem_read,
        input logic [REG_W-1:0] ex_rt,
        input logic [REG_W-1:0] id_rs,
        input logic [REG_W-1:0] id_rt,
        input logic             id_uses_rt
    );
        return ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard control: load-use bubble, fixed-latency mul/div hold and
// taken branch/jump flush, plus a saturating stall-cycle counter.
module hazard_control_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_md_start,
    input  logic             id_branch_taken,
    input  logic             id_jump,
    output logic             pc_write,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             md_release,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned MD_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [MD_W-1:0] MD_INIT = MD_W'(MD_LATENCY - 1);

    hcu_state_e      state_q, state_d;
    logic [MD_W-1:0] md_cnt_q, md_cnt_d;
    logic            lu;

    assign lu = load_use_hazard(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        pc_write    = 1'b1;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        md_release  = 1'b0;
        busy        = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (lu) begin
                    pc_write    = 1'b0;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (id_md_start) begin
                    pc_write    = 1'b0;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = S_MD_WAIT;
                    md_cnt_d    = MD_INIT;
                end else if (id_branch_taken || id_jump) begin
                    if_id_flush = 1'b1;
                end
            end
            S_MD_WAIT: begin
                busy = 1'b1;
                if (md_cnt_q != '0) begin
                    pc_write    = 1'b0;
                    if_id_stall = 1'b1;
                    id_ex_flush = 1'b1;
                    md_cnt_d    = md_cnt_q - 1'b1;
                end else begin
                    md_release  = 1'b1;
                    state_d     = S_RUN;
                end
            end
            default: state_d = S_RUN;
        endcase

        // Reset forces a bubble into both pipeline registers and freezes the PC.
        if (rst) begin
            pc_write    = 1'b0;
            if_id_stall = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            md_release  = 1'b0;
            busy        = 1'b0;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (if_id_stall),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: default instance (MD_LATENCY=4,
// CNT_W=16) and a small instance (MD_LATENCY=1, CNT_W=4) for saturation.
module tb_hazard_control_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance A inputs/outputs
    logic [4:0]  a_rs, a_rt, a_ex_rt;
    logic        a_uses_rt, a_mem_read, a_md, a_br, a_jmp;
    logic        a_pcw, a_stall, a_fflush, a_xflush, a_rel, a_busy;
    logic [15:0] a_cnt;

    // instance B inputs/outputs
    logic [4:0]  b_rs, b_rt, b_ex_rt;
    logic        b_uses_rt, b_mem_read, b_md, b_br, b_jmp;
    logic        b_pcw, b_stall, b_fflush, b_xflush, b_rel, b_busy;
    logic [3:0]  b_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    hazard_control_unit #(
        .MD_LATENCY(4),
        .CNT_W     (16)
    ) dut_a (
        .clk(clk), .rst(rst),
        .id_rs(a_rs), .id_rt(a_rt), .id_uses_rt(a_uses_rt),
        .ex_mem_read(a_mem_read), .ex_rt(a_ex_rt),
        .id_md_start(a_md), .id_branch_taken(a_br), .id_jump(a_jmp),
        .pc_write(a_pcw), .if_id_stall(a_stall), .if_id_flush(a_fflush),
        .id_ex_flush(a_xflush), .md_release(a_rel), .busy(a_busy),
        .stall_cycles(a_cnt)
    );

    hazard_control_unit #(
        .MD_LATENCY(1),
        .CNT_W     (4)
    ) dut_b (
        .clk(clk), .rst(rst),
        .id_rs(b_rs), .id_rt(b_rt), .id_uses_rt(b_uses_rt),
        .ex_mem_read(b_mem_read), .ex_rt(b_ex_rt),
        .id_md_start(b_md), .id_branch_taken(b_br), .id_jump(b_jmp),
        .pc_write(b_pcw), .if_id_stall(b_stall), .if_id_flush(b_fflush),
        .id_ex_flush(b_xflush), .md_release(b_rel), .busy(b_busy),
        .stall_cycles(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then drive new inputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check A's controls after inputs settle.
    task automatic chk_a(input string tag, input logic pcw, input logic st,
                         input logic ff, input logic xf);
        #1;
        chk({tag, ".pc_write"},    a_pcw,    pcw);
        chk({tag, ".if_id_stall"}, a_stall,  st);
        chk({tag, ".if_id_flush"}, a_fflush, ff);
        chk({tag, ".id_ex_flush"}, a_xflush, xf);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        {a_rs, a_rt, a_ex_rt, a_uses_rt, a_mem_read, a_md, a_br, a_jmp} = '0;
        {b_rs, b_rt, b_ex_rt, b_uses_rt, b_mem_read, b_md, b_br, b_jmp} = '0;

        // Reset outputs
        #2;
        chk_a("rst", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst.md_release", a_rel, 1'b0);
        chk("rst.busy", a_busy, 1'b0);
        tick(); tick();
        rst = 1'b0;
        chk_a("idle", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle.cnt", a_cnt, 0);

        // Load-use on rs
        a_mem_read = 1'b1; a_ex_rt = 5'd5; a_rs = 5'd5;
        chk_a("lu_rs", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        a_mem_read = 1'b0;
        chk_a("lu_after", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("lu_after.cnt", a_cnt, 1);

        // r0 never stalls
        a_mem_read = 1'b1; a_ex_rt = 5'd0; a_rs = 5'd0;
        chk_a("lu_r0", 1'b1, 1'b0, 1'b0, 1'b0);
        // rt match gated by id_uses_rt
        a_ex_rt = 5'd7; a_rt = 5'd7; a_rs = 5'd1; a_uses_rt = 1'b0;
        chk_a("lu_rt_unused", 1'b1, 1'b0, 1'b0, 1'b0);
        a_uses_rt = 1'b1;
        chk_a("lu_rt_used", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        a_mem_read = 1'b0; a_uses_rt = 1'b0;
        chk("lu_rt.cnt", a_cnt, 2);

        // Mul/div with MD_LATENCY=4, id_md_start held high
        a_md = 1'b1;
        chk_a("md_t0", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("md_t0.busy", a_busy, 1'b0);
        chk("md_t0.rel", a_rel, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) a_md = 1'b0;
            #1;
            chk("md.busy", a_busy, 1'b1);
            chk("md.stall", a_stall, (k < 4) ? 1'b1 : 1'b0);
            chk("md.rel", a_rel, (k == 4) ? 1'b1 : 1'b0);
            chk("md.pc_write", a_pcw, (k == 4) ? 1'b1 : 1'b0);
        end
        tick();
        #1;
        chk("md_done.busy", a_busy, 1'b0);
        chk("md_done.rel", a_rel, 1'b0);
        chk("md_done.cnt", a_cnt, 6);

        // Priority: load-use beats taken branch
        a_mem_read = 1'b1; a_ex_rt = 5'd5; a_rs = 5'd5; a_br = 1'b1;
        chk_a("prio_lu_br", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        a_mem_read = 1'b0;
        chk_a("prio_br", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("prio.cnt", a_cnt, 7);
        a_br = 1'b0; a_jmp = 1'b1;
        chk_a("jump", 1'b1, 1'b0, 1'b1, 1'b0);
        a_jmp = 1'b0;

        // Reset in the middle of a mul/div wait
        tick();
        a_md = 1'b1;
        chk_a("mdr_t0", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        a_md = 1'b0;
        #1;
        chk("mdr_t1.busy", a_busy, 1'b1);
        tick();
        rst = 1'b1;
        chk_a("mdr_rst", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("mdr_rst.busy", a_busy, 1'b0);
        tick();
        rst = 1'b0;
        chk_a("mdr_after", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mdr_after.busy", a_busy, 1'b0);
        chk("mdr_after.cnt", a_cnt, 0);

        // Instance B: MD_LATENCY=1 gives one stall then release
        b_md = 1'b1;
        #1;
        chk("b_md.stall", b_stall, 1'b1);
        tick();
        b_md = 1'b0;
        #1;
        chk("b_md1.busy", b_busy, 1'b1);
        chk("b_md1.rel", b_rel, 1'b1);
        chk("b_md1.stall", b_stall, 1'b0);
        tick();
        #1;
        chk("b_md2.busy", b_busy, 1'b0);
        chk("b_md2.cnt", b_cnt, 1);

        // Saturation at 15 with CNT_W=4
        b_mem_read = 1'b1; b_ex_rt = 5'd3; b_rs = 5'd3;
        for (int k = 0; k < 20; k++) tick();
        chk("b_sat20.cnt", b_cnt, 15);
        tick(); tick();
        chk("b_sat22.cnt", b_cnt, 15);
        #1;
        chk("b_sat.stall", b_stall, 1'b1);
        b_mem_read = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
